// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for systolic_4x4: collect weights/inputs, burst them gap-free, capture results.
// Optional weight reuse across jobs: define SYSTOLIC_SEQ_WEIGHT_REUSE_EN.
`timescale 1ns/1ps
module systolic_seq_ctrl #(
    parameter int N              = 4,
    parameter int DATA_W         = 4,
    parameter int ACC_W          = 8,
    parameter int COMPUTE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
`ifdef SYSTOLIC_SEQ_WEIGHT_REUSE_EN
    input  logic                 start_reuse_w,
`endif
    output logic                 busy,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 array_reset,
    output logic [DATA_W-1:0]    array_data_in,
    output logic                 array_load_w,
    output logic                 array_load_x,
    input  logic [N*ACC_W-1:0]   array_results,
    output logic [N*ACC_W-1:0]   res_data,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(COMPUTE_CYCLES + 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT_W,
        COLLECT_X,
        CLEAR,
        PUSH_W,
        PUSH_X,
        COMPUTE,
        RESULT
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   wbuf_q [N];
    logic [DATA_W-1:0]   wbuf_d [N];
    logic [DATA_W-1:0]   xbuf_q [N];
    logic [DATA_W-1:0]   xbuf_d [N];
    logic                busy_q, busy_d;
    logic                s_ready_q, s_ready_d;
    logic                array_reset_q, array_reset_d;
    logic [DATA_W-1:0]   array_data_in_q, array_data_in_d;
    logic                array_load_w_q, array_load_w_d;
    logic                array_load_x_q, array_load_x_d;
    logic [N*ACC_W-1:0]  res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic                beat;
    logic                reuse_w;

`ifdef SYSTOLIC_SEQ_WEIGHT_REUSE_EN
    assign reuse_w = start_reuse_w;
`else
    assign reuse_w = 1'b0;
`endif

    assign beat    = s_valid && s_ready_q;
    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        wbuf_d          = wbuf_q;
        xbuf_d          = xbuf_q;
        array_data_in_d = array_data_in_q;
        res_data_d      = res_data_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = reuse_w ? COLLECT_X : COLLECT_W;
                end
            end
            COLLECT_W: begin
                if (beat) begin
                    wbuf_d[idx_q] = s_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = COLLECT_X;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            COLLECT_X: begin
                if (beat) begin
                    xbuf_d[idx_q] = s_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = CLEAR;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            CLEAR: begin
                idx_d           = '0;
                array_data_in_d = wbuf_q[0];
                state_d         = PUSH_W;
            end
            // idx tracks the word currently on array_data_in
            PUSH_W: begin
                if (idx_q == IDX_LAST) begin
                    idx_d           = '0;
                    array_data_in_d = xbuf_q[0];
                    state_d         = PUSH_X;
                end else begin
                    idx_d           = idx_nxt;
                    array_data_in_d = wbuf_q[idx_nxt];
                end
            end
            PUSH_X: begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    idx_d           = idx_nxt;
                    array_data_in_d = xbuf_q[idx_nxt];
                end
            end
            // first COMPUTE cycle is the last load landing in the array
            COMPUTE: begin
                if (cnt_q == CNT_LAST) begin
                    res_data_d = array_results;
                    state_d    = RESULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d         = (state_d != IDLE);
        s_ready_d      = (state_d == COLLECT_W) || (state_d == COLLECT_X);
        array_reset_d  = (state_d == CLEAR);
        array_load_w_d = (state_d == PUSH_W);
        array_load_x_d = (state_d == PUSH_X);
        res_valid_d    = (state_d == RESULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            wbuf_q          <= '{default: '0};
            xbuf_q          <= '{default: '0};
            busy_q          <= 1'b0;
            s_ready_q       <= 1'b0;
            array_reset_q   <= 1'b1;
            array_data_in_q <= '0;
            array_load_w_q  <= 1'b0;
            array_load_x_q  <= 1'b0;
            res_data_q      <= '0;
            res_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            wbuf_q          <= wbuf_d;
            xbuf_q          <= xbuf_d;
            busy_q          <= busy_d;
            s_ready_q       <= s_ready_d;
            array_reset_q   <= array_reset_d;
            array_data_in_q <= array_data_in_d;
            array_load_w_q  <= array_load_w_d;
            array_load_x_q  <= array_load_x_d;
            res_data_q      <= res_data_d;
            res_valid_q     <= res_valid_d;
        end
    end

    assign busy          = busy_q;
    assign s_ready       = s_ready_q;
    assign array_reset   = array_reset_q;
    assign array_data_in = array_data_in_q;
    assign array_load_w  = array_load_w_q;
    assign array_load_x  = array_load_x_q;
    assign res_data      = res_data_q;
    assign res_valid     = res_valid_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl with a behavioural 4-channel array model.
`timescale 1ns/1ps
module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
`ifdef SYSTOLIC_SEQ_WEIGHT_REUSE_EN
    logic              start_reuse_w = 1'b0;
`endif
    logic              busy;
    logic [DW-1:0]     s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              array_reset;
    logic [DW-1:0]     array_data_in;
    logic              array_load_w;
    logic              array_load_x;
    logic [N*AW-1:0]   array_results;
    logic [N*AW-1:0]   res_data;
    logic              res_valid;
    logic              res_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int beats = 0;
    logic [N*AW-1:0] exp_q[$];

    systolic_seq_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
`ifdef SYSTOLIC_SEQ_WEIGHT_REUSE_EN
        .start_reuse_w(start_reuse_w),
`endif
        .busy(busy),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .array_reset(array_reset),
        .array_data_in(array_data_in),
        .array_load_w(array_load_w),
        .array_load_x(array_load_x),
        .array_results(array_results),
        .res_data(res_data),
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // array model: load strobes fill slots in order, any other cycle accumulates w*x
    logic [DW-1:0] mw [N];
    logic [DW-1:0] mx [N];
    logic [AW-1:0] macc [N];
    int mwi, mxi;

    always @(posedge clk) begin
        if (array_reset) begin
            for (int k = 0; k < N; k++) begin
                mw[k]   <= '0;
                mx[k]   <= '0;
                macc[k] <= '0;
            end
            mwi <= 0;
            mxi <= 0;
        end else if (array_load_w) begin
            mw[mwi] <= array_data_in;
            mwi     <= (mwi + 1) % N;
        end else if (array_load_x) begin
            mx[mxi] <= array_data_in;
            mxi     <= (mxi + 1) % N;
        end else begin
            for (int k = 0; k < N; k++)
                macc[k] <= macc[k] + AW'(mw[k]) * AW'(mx[k]);
        end
    end

    always_comb begin
        array_results = '0;
        for (int k = 0; k < N; k++)
            array_results[k*AW +: AW] = macc[k];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: result scoreboard, hold stability, strobe burst shape
    initial begin
        logic            pv;
        logic            pr;
        logic [N*AW-1:0] pd;
        int              pos;
        bit              ok;
        pv = 1'b0; pr = 1'b0; pd = '0; pos = 0; ok = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv  = 1'b0;
                pos = 0;
            end else begin
                if (s_valid && s_ready) beats++;
                if (pv && !pr)
                    check("res_hold", 64'({res_valid, res_data}), 64'({1'b1, pd}));
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result: got %0h expected none", res_data);
                    end else begin
                        check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
                    end
                end
                pv = res_valid;
                pr = res_ready;
                pd = res_data;
                if (array_reset && busy) begin
                    pos = 1;
                    ok  = 1'b1;
                end else if (pos > 0) begin
                    if (pos <= N)
                        ok &= array_load_w && !array_load_x;
                    else if (pos <= 2*N)
                        ok &= array_load_x && !array_load_w;
                    else
                        ok &= !array_load_w && !array_load_x;
                    if (pos == 2*N + 1) begin
                        check("strobe_seq", 64'(ok), 64'(1));
                        pos = 0;
                    end else begin
                        pos++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input bit reuse);
`ifdef SYSTOLIC_SEQ_WEIGHT_REUSE_EN
        start_reuse_w = reuse;
`else
        if (reuse) $display("reuse requested without reuse build");
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef SYSTOLIC_SEQ_WEIGHT_REUSE_EN
        start_reuse_w = 1'b0;
`endif
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit gap);
        int t;
        t = 0;
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("beat_ready", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_job(input logic [15:0] wv, input logic [15:0] xv,
                           input bit gap, input bit reuse, input logic [31:0] expv);
        exp_q.push_back(expv);
        do_start(reuse);
        if (!reuse)
            for (int k = 0; k < N; k++) send_word(wv[k*4 +: 4], gap);
        for (int k = 0; k < N; k++) send_word(xv[k*4 +: 4], gap);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(busy), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ctl"},
              64'({busy, s_ready, array_load_w, array_load_x, res_valid, array_reset}),
              64'(6'b000001));
        check({name, "_data"}, 64'({array_data_in, res_data}), 64'(0));
    endtask

    initial begin
        int e;
        int b0;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release", 64'({array_reset, busy}), 64'(0));

        // 1: basic job and latency from last input beat
        run_job(16'h4321, 16'h1111, 1'b0, 1'b0, 32'h04030201);
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!res_valid && e < 30);
        check("latency", 64'(e), 64'(11));
        wait_idle("t1_idle");

        // 2: stalled stream, identical results
        run_job(16'h4321, 16'h1111, 1'b1, 1'b0, 32'h04030201);
        wait_idle("t2_idle");

        // 3: consumer back-pressure, start in handshake cycle ignored
        res_ready = 1'b0;
        run_job(16'h01FF, 16'h792F, 1'b0, 1'b0, 32'h00091EE1);
        e = 0;
        while (!res_valid && e < 40) begin
            @(posedge clk);
            #1;
            e++;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t3_after_ready", 64'({res_valid, busy}), 64'(0));
        @(posedge clk);
        #1;
        check("t3_start_ignored", 64'({busy, s_ready}), 64'(0));

        // 4: start pulses during PUSH_X and COMPUTE are ignored
        run_job(16'h1413, 16'h6295, 1'b0, 1'b0, 32'h0608090F);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("t4_idle");
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("t4_no_second_job", 64'({busy, s_ready}), 64'(0));

        // 5: reset during COLLECT_X, then a fresh job
        do_start(1'b0);
        for (int k = 0; k < N; k++) send_word(4'(k + 9), 1'b0);
        send_word(4'd7, 1'b0);
        send_word(4'd7, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals("t5_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_release", 64'({array_reset, busy, s_ready}), 64'(0));
        run_job(16'h8765, 16'h2132, 1'b0, 1'b0, 32'h1007120A);
        wait_idle("t5_idle");

`ifdef SYSTOLIC_SEQ_WEIGHT_REUSE_EN
        // 6: second job reuses the previous weights
        run_job(16'h2222, 16'h1111, 1'b0, 1'b0, 32'h02020202);
        wait_idle("t6a_idle");
        b0 = beats;
        run_job(16'h0000, 16'h3333, 1'b0, 1'b1, 32'h06060606);
        wait_idle("t6b_idle");
        check("t6_beats", 64'(beats - b0), 64'(4));
`else
        b0 = 0;
`endif

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
